// File: rtl/ahb_slave_pkg.sv
// Shared bus codes and FSM states for the AHB-Lite memory slave.
package ahb_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite signal bundle between a single master and the memory slave.
interface ahb_slave_mem_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic                 hsel;
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [dataWidth-1:0] hwdata;
  logic                 hready;
  logic                 hresp;
  logic [dataWidth-1:0] hrdata;

  modport master (
    output hsel, htrans, haddr, hwrite, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, haddr, hwrite, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem_array.sv
// depth x dataWidth storage: one write port, one registered read port with
// write-to-read forwarding so a same-edge read sees the data being written.
module ahb_slave_mem_array #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32,
  parameter int depth     = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [addrWidth-1:0] wr_addr,
  input  logic [dataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_clr,
  input  logic [addrWidth-1:0] rd_addr,
  output logic [dataWidth-1:0] rd_data
);
  localparam int IdxW = (depth > 1) ? $clog2(depth) : 1;

  logic [dataWidth-1:0] mem [depth];
  logic [dataWidth-1:0] rd_data_q, rd_data_d;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IdxW-1:0]] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_clr)                             rd_data_d = '0;
      else if (wr_en && (wr_addr == rd_addr)) rd_data_d = wr_data;
      else                                    rd_data_d = mem[rd_addr[IdxW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: accept logic, response FSM, wait counter and the
// pending write that commits at the edge ending its data phase.
module ahb_slave_mem
  import ahb_slave_pkg::*;
#(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int depth      = 2**addrWidth,
  parameter int waitStates = 0
) (
  input  logic           hclk,
  input  logic           hresetn,
  ahb_slave_mem_if.slave bus
);
  typedef struct packed {
    logic                 vld;
    logic [addrWidth-1:0] addr;
  } pend_t;

  localparam logic [addrWidth:0]   DepthLim = depth[addrWidth:0];
  localparam logic [WAIT_W-1:0]    WsLoad   = (waitStates > 0) ? WAIT_W'(waitStates - 1) : '0;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  pend_t             pend_q, pend_d;
  logic              hready, hresp, accept, in_range, commit;
  logic [dataWidth-1:0] rd_data;

  assign in_range = {1'b0, bus.haddr} < DepthLim;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    unique case (state_q)
      ST_WAIT: begin
        hready = 1'b0;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - WAIT_W'(1);
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    accept = hready && bus.hsel && is_active(bus.htrans);
    // Any hready=1 edge ends the current data phase, so the pending write retires.
    if (hready) pend_d.vld = 1'b0;
    if (accept) begin
      if (in_range) begin
        pend_d = '{vld: bus.hwrite, addr: bus.haddr};
        if (waitStates > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WsLoad;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d = ST_ERR1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign commit = hready && pend_q.vld;

  ahb_slave_mem_array #(
    .addrWidth(addrWidth),
    .dataWidth(dataWidth),
    .depth    (depth)
  ) u_array (
    .clk    (hclk),
    .rst_n  (hresetn),
    .wr_en  (commit),
    .wr_addr(pend_q.addr),
    .wr_data(bus.hwdata),
    .rd_en  (accept && !bus.hwrite),
    .rd_clr (!in_range),
    .rd_addr(bus.haddr),
    .rd_data(rd_data)
  );

  assign bus.hready = hready;
  assign bus.hresp  = hresp;
  assign bus.hrdata = rd_data;
endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Synthesizable AHB-Lite slave with a word-addressed memory array, programmable wait-state insertion and ERROR responses for out-of-range addresses. It sits directly downstream of the bench AHB master: it consumes that master's htrans/haddr/hwrite/hwdata and returns hready/hrdata/hresp. Primary use is as the reference target for exercising master pipelining, read-data capture and wait-state handling.

## Interface
Parameters:
- addrWidth, 8, haddr width; one address = one dataWidth word (no hsize/byte lanes)
- dataWidth, 32, hwdata/hrdata width
- depth, 2**addrWidth, number of implemented words; addresses >= depth are out of range
- waitStates, 0, wait cycles inserted in every OKAY data phase (0..15)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - hclk  input  1  clock; all sampling on posedge
  - hresetn  input  1  asynchronous, active-low reset
- hsel  input  1  slave select; tie 1 when this is the only slave
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- haddr  input  addrWidth  word address
- hwrite  input  1  1=write, 0=read
- hwdata  input  dataWidth  write data, valid in the data phase
- hready  output  1  data-phase complete / slave ready for a new address
- hresp  output  1  0=OKAY, 1=ERROR
- hrdata  output  dataWidth  read data, valid when hready=1 at the end of a read data phase

## Operation
- Accept: at a posedge with hready=1, hsel=1 and htrans[1]=1, an address phase is accepted. Latch addr, write flag and in-range flag (addr < depth).
- IDLE/BUSY, or hsel=0 with hready=1: no access; the next cycle is a zero-wait OKAY.
- State machine (states in package):
  - ST_IDLE: hready=1, hresp=0.
  - Accept in range with waitStates>0 -> ST_WAIT; waitStates=0 -> stay ST_IDLE, giving a single-cycle data phase.
  - Accept out of range -> ST_ERR1.
  - ST_WAIT: hready=0; 4-bit counter loaded with waitStates-1 on accept, decrements each cycle; at 0 -> ST_IDLE.
  - ST_ERR1: hready=0, hresp=1 -> ST_ERR2.
  - ST_ERR2: hready=1, hresp=1. May accept the next address -> ST_IDLE, ST_WAIT or ST_ERR1.
- Read:
  - hrdata is loaded on the accept edge from mem[addr] and held until the next read accept.
  - Out-of-range read loads 0.
- Write:
  - hwdata is sampled and written to mem[addr] at the posedge that ends the data phase (hready=1).
  - Out-of-range writes are discarded.
- Forwarding: a read accepted on the same edge that commits a write to the same address loads hwdata into hrdata, not stale memory.
- hready=0 at a posedge: address/control inputs are ignored; the master holds them.

## Timing
- Reset values: hready=1, hresp=0, hrdata=0, state ST_IDLE, counter 0, pending write cleared. Memory contents are not reset.
- Reset mid-operation (ST_WAIT/ST_ERRx): abort immediately to the reset values. The pending write is dropped.
- OKAY data phase length: waitStates+1 cycles; hready is low for exactly waitStates cycles.
- ERROR response: always 2 cycles, independent of waitStates.
- Back-to-back NONSEQ: with waitStates=0 there is one transfer per cycle, no bubbles.
- Read latency, waitStates=0: data valid one cycle after the accept edge.

## Structure
- Package ahb_slave_pkg: htrans codes (IDLE, BUSY, NONSEQ, SEQ), hresp codes (OKAY, ERROR), state enum (ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2).
- Sub-module ahb_slave_mem_array (depth x dataWidth):
  - one write port, one registered read port
  - read-during-write to the same address returns the write data (forwarding lives here)
- Top: accept logic, FSM, wait counter, pending-write registers.

## Test plan
- Reset/idle: hresetn low then high, htrans=IDLE -> hready=1, hresp=0, hrdata=0 every cycle.
- Zero-wait write/read, waitStates=0: write 'h10 <- 'hDEADBEEF, then read 'h10 back-to-back -> hrdata='hDEADBEEF one cycle after the read accept (exercises forwarding); hready never low.
- Wait states, waitStates=3: read 'h04 after writing 'h12345678 -> hready low 3 cycles, then high with hrdata='h12345678; each data phase is 4 cycles.
- Error, depth=128: write to 'h80 -> hready=0/hresp=1, then hready=1/hresp=1; a subsequent read of 'h80 returns 0 with ERROR; mem[0..127] unchanged.
- Reset mid-wait, waitStates=5: assert hresetn low 2 cycles into a write to 'h20 -> hready=1 immediately; a later read of 'h20 returns the pre-write value.
- Pipelined mix: NONSEQ W 'h01 ='hA, R 'h01, W 'h02 ='hB, R 'h02 with no idles -> reads return 'hA then 'hB, 4 transfers in 5 cycles.
